alu_pipe: RTL and testbench

//   Parametrised, pipelined integer ALU for the execute stage; successor to the 64-bit combinational ALU.

---
 rtl/alu_pipe.sv | 249 ++++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined RV32/RV64 integer ALU for the execute stage.
//   S1 registers operands and the decoded op; S2 registers the result.
//   RV64 *W word ops, valid/ready handshake with backpressure, tag sideband.
//   Optional feature macro: ALU_MUL_EN. When defined, it adds a radix-2 iterative
//   multiplier in S1 for MUL/MULH/MULHSU/MULHU/MULW.
// Parameters:
//   XLEN   datapath width, 32 or 64
//   TAG_W  width of the tag sideband
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     issue-side handshake
//   in_rs1, in_rs2        operands
//   in_funct3, in_funct7  RISC-V funct3 and funct7[5] alt bit
//   in_word, in_mul       *W op select, M-extension select
//   in_tag                sideband returned unchanged on out_tag
//   out_valid/out_ready   writeback-side handshake
//   out_rd, out_tag       result and its tag
//   busy                  any stage occupied or multiplier running

module alu_pipe #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7,
  input  logic             in_word,
  input  logic             in_mul,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_rd,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  if (XLEN != 32 && XLEN != 64) begin : gen_xlen_check
    $error("alu_pipe: XLEN must be 32 or 64");
  end

  localparam int unsigned ShW = $clog2(XLEN);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Handshake and stage state
  logic             rdy_en_q;
  logic             s1_valid_q, s1_valid_d;
  logic [XLEN-1:0]  s1_rs1_q, s1_rs2_q;
  logic [2:0]       s1_funct3_q;
  logic             s1_alt_q, s1_word_q, s1_mul_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_rd_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             in_word_eff;
  logic             s2_free, s1_adv, accept;
  logic             mul_op, mul_wait;
  logic [XLEN-1:0]  mul_res, alu_res, result;

  // Word ops exist only on RV64.
  assign in_word_eff = (XLEN == 64) ? in_word : 1'b0;

  assign s2_free  = ~out_valid_q | out_ready;
  assign s1_adv   = s1_valid_q & ~mul_wait & s2_free;
  // rdy_en_q holds in_ready low until the first edge after reset release.
  assign in_ready = rdy_en_q & (~s1_valid_q | s1_adv);
  assign accept   = in_valid & in_ready;

  assign s1_valid_d  = accept | (s1_valid_q & ~s1_adv);
  assign out_valid_d = s1_adv | (out_valid_q & ~out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_funct3_q <= '0;
      s1_alt_q    <= 1'b0;
      s1_word_q   <= 1'b0;
      s1_mul_q    <= 1'b0;
      s1_tag_q    <= '0;
    end else begin
      rdy_en_q   <= 1'b1;
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_rs1_q    <= in_rs1;
        s1_rs2_q    <= in_rs2;
        s1_funct3_q <= in_funct3;
        s1_alt_q    <= in_funct7;
        s1_word_q   <= in_word_eff;
        s1_mul_q    <= mul_op;
        s1_tag_q    <= in_tag;
      end
    end
  end

  // Plain ALU, evaluated from the S1 registers
  logic [ShW-1:0]  shamt;
  logic [4:0]      shamt_w;
  logic [XLEN-1:0] add_res, sra_res;
  logic [31:0]     sraw_res, word_res;
  logic            slt, sltu;

  always_comb begin
    shamt    = s1_rs2_q[ShW-1:0];
    shamt_w  = s1_rs2_q[4:0];
    add_res  = s1_alt_q ? (s1_rs1_q - s1_rs2_q) : (s1_rs1_q + s1_rs2_q);
    // Kept as standalone assignments so >>> stays arithmetic.
    sra_res  = $signed(s1_rs1_q) >>> shamt;
    sraw_res = $signed(s1_rs1_q[31:0]) >>> shamt_w;
    slt      = $signed(s1_rs1_q) < $signed(s1_rs2_q);
    sltu     = s1_rs1_q < s1_rs2_q;
    word_res = '0;
    alu_res  = '0;
    if (s1_word_q) begin
      unique case (s1_funct3_q)
        3'd0:    word_res = add_res[31:0];
        3'd1:    word_res = s1_rs1_q[31:0] << shamt_w;
        3'd5:    word_res = s1_alt_q ? sraw_res : (s1_rs1_q[31:0] >> shamt_w);
        default: word_res = '0;
      endcase
      alu_res = sext32(word_res);
    end else begin
      unique case (s1_funct3_q)
        3'd0:    alu_res = add_res;
        3'd1:    alu_res = s1_rs1_q << shamt;
        3'd2:    alu_res = XLEN'(slt);
        3'd3:    alu_res = XLEN'(sltu);
        3'd4:    alu_res = s1_rs1_q ^ s1_rs2_q;
        3'd5:    alu_res = s1_alt_q ? sra_res : (s1_rs1_q >> shamt);
        3'd6:    alu_res = s1_rs1_q | s1_rs2_q;
        default: alu_res = s1_rs1_q & s1_rs2_q;
      endcase
    end
  end

`ifdef ALU_MUL_EN
  localparam logic [ShW:0] ItersFull = (ShW+1)'(XLEN);
  localparam logic [ShW:0] ItersWord = (ShW+1)'(32);

  logic              mul_start, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d, prod;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [ShW:0]      cnt_q, cnt_d;
  logic              neg_q, neg_d;

  assign mul_op    = in_mul;
  // Only MUL..MULHU and MULW launch the iterative unit; other mul encodings yield 0.
  assign mul_start = in_mul & ~in_funct3[2] & (~in_word_eff | (in_funct3 == 3'd0));

  // Signed operands are multiplied as magnitudes; the sign is reapplied to the
  // full 2*XLEN product, so XLEN iterations suffice for every variant.
  always_comb begin
    a_neg    = ((in_funct3 == 3'd1) | (in_funct3 == 3'd2)) & in_rs1[XLEN-1] & ~in_word_eff;
    b_neg    = (in_funct3 == 3'd1) & in_rs2[XLEN-1] & ~in_word_eff;
    a_mag    = a_neg ? -in_rs1 : in_rs1;
    b_mag    = b_neg ? -in_rs2 : in_rs2;
    if (in_word_eff) begin
      a_mag = XLEN'(in_rs1[31:0]);
      b_mag = XLEN'(in_rs2[31:0]);
    end
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    if (accept && mul_start) begin
      acc_d    = '0;
      mcand_d  = {{XLEN{1'b0}}, a_mag};
      mplier_d = b_mag;
      cnt_d    = in_word_eff ? ItersWord : ItersFull;
      neg_d    = a_neg ^ b_neg;
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - (ShW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  assign prod     = neg_q ? -acc_q : acc_q;
  assign mul_wait = (cnt_q != '0);

  always_comb begin
    mul_res = '0;
    if (!s1_funct3_q[2] && !(s1_word_q && (s1_funct3_q != 3'd0))) begin
      if (s1_funct3_q == 3'd0) begin
        mul_res = s1_word_q ? sext32(prod[31:0]) : prod[XLEN-1:0];
      end else begin
        mul_res = prod[2*XLEN-1:XLEN];
      end
    end
  end
`else
  logic unused_mul;
  assign unused_mul = in_mul;
  assign mul_op     = 1'b0;
  assign mul_wait   = 1'b0;
  assign mul_res    = '0;
`endif

  assign result = s1_mul_q ? mul_res : alu_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s1_adv) begin
        out_rd_q  <= result;
        out_tag_q <= s1_tag_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_rd    = out_rd_q;
  assign out_tag   = out_tag_q;
  assign busy      = s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (XLEN=64, TAG_W=5).
// Expected results are queued at accept and compared as the DUT emits them.

module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic        in_funct7, in_word, in_mul;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready;
  logic [63:0] out_rd;
  logic [4:0]  out_tag;
  logic        busy;

  alu_pipe #(.XLEN(64), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_word   (in_word),
    .in_mul    (in_mul),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rd    (out_rd),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rd;
    logic [4:0]  tag;
    int          acc;
    int          lat;  // 0 = latency not checked
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  bit          head_seen = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
    end
  endtask

  // Outputs sampled on the falling edge; a transfer seen here completes on the next rise.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        if (!head_seen) begin
          head_seen = 1'b1;
          if (sb[0].lat != 0) check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
        end
        if (out_ready) begin
          mon_e = sb.pop_front();
          check("rd", out_rd, mon_e.rd);
          check("tag", 64'(out_tag), 64'(mon_e.tag));
          head_seen = 1'b0;
        end else begin
          check("hold_rd", out_rd, sb[0].rd);
          check("hold_tag", 64'(out_tag), 64'(sb[0].tag));
        end
      end
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3,
                      input logic f7, input logic w, input logic m, input logic [4:0] tg,
                      input logic [63:0] exp, input int lat);
    int   n;
    exp_t e;
    n         = 0;
    in_valid  = 1'b1;
    in_rs1    = a;
    in_rs2    = b;
    in_funct3 = f3;
    in_funct7 = f7;
    in_word   = w;
    in_mul    = m;
    in_tag    = tg;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      e.rd  = exp;
      e.tag = tg;
      e.acc = cyc;
      e.lat = lat;
      sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_funct3 = '0;
    in_funct7 = 1'b0;
    in_word   = 1'b0;
    in_mul    = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_rd", out_rd, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 check("in_ready_after_edge", 64'(in_ready), 64'd1);

    // Plain ALU ops, back to back at full rate
    send(64'd1, 64'd2, 3'd0, 1'b0, 1'b0, 1'b0, 5'd3, 64'd3, 2);
    send(64'd1, 64'd2, 3'd0, 1'b1, 1'b0, 1'b0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    send(64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 3'd5, 1'b1, 1'b0, 1'b0, 5'd5,
         64'hFFFF_FFFF_FFFF_FFFC, 2);
    send(64'd6, 64'd2, 3'd5, 1'b0, 1'b0, 1'b0, 5'd6, 64'd1, 2);
    send(64'd6, 64'd66, 3'd5, 1'b0, 1'b0, 1'b0, 5'd7, 64'd1, 2);
    send(64'hFFFF_FFFF_FFFF_FFF3, 64'd2, 3'd2, 1'b0, 1'b0, 1'b0, 5'd8, 64'd1, 2);
    send(64'hFFFF_FFFF_FFFF_FFF3, 64'd2, 3'd3, 1'b0, 1'b0, 1'b0, 5'd9, 64'd0, 2);
    send(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 3'd2, 1'b0, 1'b0, 1'b0, 5'd10,
         64'd0, 2);
    send(64'h7FFF_FFFF, 64'd1, 3'd0, 1'b0, 1'b1, 1'b0, 5'd11, 64'hFFFF_FFFF_8000_0000, 2);
    send(64'h8000_0000, 64'd4, 3'd5, 1'b1, 1'b1, 1'b0, 5'd12, 64'hFFFF_FFFF_F800_0000, 2);
    send(64'd1, 64'd31, 3'd1, 1'b0, 1'b1, 1'b0, 5'd13, 64'hFFFF_FFFF_8000_0000, 2);
    send(64'hFFFF_FFFF_8000_0000, 64'd4, 3'd5, 1'b0, 1'b1, 1'b0, 5'd14, 64'h0800_0000, 2);
    send(64'd5, 64'd3, 3'd4, 1'b0, 1'b1, 1'b0, 5'd15, 64'd0, 2);
    send(64'hF0F0, 64'hFF00, 3'd4, 1'b1, 1'b0, 1'b0, 5'd16, 64'h0FF0, 2);
    send(64'hF0F0, 64'hFF00, 3'd6, 1'b0, 1'b0, 1'b0, 5'd17, 64'hFFF0, 2);
    send(64'hF0F0, 64'hFF00, 3'd7, 1'b0, 1'b0, 1'b0, 5'd18, 64'hF000, 2);
    send(64'd1, 64'd63, 3'd1, 1'b0, 1'b0, 1'b0, 5'd19, 64'h8000_0000_0000_0000, 2);
`ifndef ALU_MUL_EN
    send(64'd1, 64'd2, 3'd0, 1'b0, 1'b0, 1'b1, 5'd20, 64'd3, 2);
`endif
    drain();

    // Backpressure: four ops, consumer stalls three cycles after the first result
    @(posedge clk);
    #1 out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          send(64'(i * 10 + 1), 64'd5, 3'd0, 1'b0, 1'b0, 1'b0, 5'(i), 64'(i * 10 + 6), 0);
        end
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
          n++;
          @(negedge clk);
        end
        check("stall_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("no_gap", 64'(out_valid), 64'd1);
        end
      end
    join
    drain();

`ifdef ALU_MUL_EN
    // Multiplier
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'd3, 1'b0, 1'b0, 1'b1, 5'd21, 64'd1, 66);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("mul_stall_cycles", 64'(n), 64'd64);
    send(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 3'd0, 1'b0, 1'b0, 1'b1, 5'd22,
         64'hFFFF_FFFF_FFFF_FFF1, 66);
    send(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 3'd1, 1'b0, 1'b0, 1'b1, 5'd23,
         64'hFFFF_FFFF_FFFF_FFFF, 66);
    send(64'd5, 64'd3, 3'd5, 1'b0, 1'b0, 1'b1, 5'd24, 64'd0, 2);
    drain();

    // Reset mid-multiply
    send(64'd3, 64'd5, 3'd0, 1'b0, 1'b0, 1'b1, 5'd25, 64'd15, 0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    head_seen = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_busy_after", 64'(busy), 64'd0);
    @(posedge clk);
    #1 send(64'd7, 64'd8, 3'd0, 1'b0, 1'b0, 1'b0, 5'd26, 64'd15, 2);
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
